// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg -- shared definitions for simple sys_bus initiators.
// Contents:
//   dma_state_t  : DMA copy engine state encoding (IDLE, RD, WR, DONE)
//   WSTRB_FULL   : byte-enable pattern for a full 32-bit write
//   WORD_BYTES   : address increment per 32-bit word
//   word_align() : clears the byte-offset bits of a byte address
package sys_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_DONE = 2'd3
   } dma_state_t;

   localparam logic [3:0]  WSTRB_FULL = 4'hF;
   localparam logic [31:0] WORD_BYTES = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/dma_timeout.sv
// dma_timeout -- bus-wait watchdog used by dma_copy when DMA_TIMEOUT_EN is set.
// Ports:
//   clk     : system clock
//   resetn  : asynchronous active-low reset
//   run     : high while a request is outstanding and not yet accepted
//   expired : high in the CYCLES-th consecutive cycle that run is high
// The count restarts whenever run drops, so every bus beat gets a fresh budget.
module dma_timeout #(
   parameter int unsigned CYCLES = 1024
) (
   input  logic clk,
   input  logic resetn,
   input  logic run,
   output logic expired
);

   localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [CW-1:0] cnt_reg;

   // The first waiting cycle sees cnt_reg == 0, so CYCLES-1 marks the last one.
   assign expired = run && (cnt_reg == CW'(CYCLES - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_reg <= '0;
      end else if (!run) begin
         cnt_reg <= '0;
      end else if (!expired) begin
         cnt_reg <= cnt_reg + CW'(1);
      end
   end

endmodule

// File: rtl/dma_copy.sv
// dma_copy -- single-channel word copy engine on a sys_bus initiator port.
// Reads len 32-bit words from src_addr and writes them to dst_addr, one
// read beat and one write beat per word, with an idle cycle between beats.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   start                : one-cycle request (accepted only when idle)
//   src_addr, dst_addr   : byte addresses, low two bits ignored
//   len                  : number of words (0 = complete immediately)
//   abort                : stop after the current word's write
//   busy, done, error    : status; done is a one-cycle pulse, error sticky
//   mem_valid/addr/wdata/wstrb : bus request (wstrb = 0 marks a read)
//   mem_ready, mem_rdata : bus response
// Build option: define DMA_TIMEOUT_EN to abandon a beat after TIMEOUT_CYCLES
// of waiting for mem_ready and raise error; otherwise the engine waits forever
// and error is tied low.
module dma_copy
   import sys_bus_pkg::*;
#(
   parameter int unsigned LEN_W          = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic             mem_valid,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_wstrb,
   input  logic             mem_ready,
   input  logic [31:0]      mem_rdata
);

   dma_state_t       state_reg;
   logic [31:0]      src_ptr_reg;
   logic [31:0]      dst_ptr_reg;
   logic [LEN_W-1:0] count_reg;
   logic             abort_reg;
   logic             timeout_hit;
   logic             last_beat;

`ifdef DMA_TIMEOUT_EN
   logic error_reg;

   dma_timeout #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .resetn  (resetn),
      .run     (mem_valid && !mem_ready),
      .expired (timeout_hit)
   );

   assign error = error_reg;
`else
   assign timeout_hit = 1'b0;
   assign error       = 1'b0;
`endif

   // An abort arriving in the same cycle as the final write handshake still counts.
   assign last_beat = (count_reg == LEN_W'(1)) || abort_reg || abort;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg   <= ST_IDLE;
         src_ptr_reg <= '0;
         dst_ptr_reg <= '0;
         count_reg   <= '0;
         abort_reg   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_valid   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_wstrb   <= '0;
`ifdef DMA_TIMEOUT_EN
         error_reg   <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  src_ptr_reg <= word_align(src_addr);
                  dst_ptr_reg <= word_align(dst_addr);
                  count_reg   <= len;
                  abort_reg   <= 1'b0;
                  busy        <= 1'b1;
`ifdef DMA_TIMEOUT_EN
                  error_reg   <= 1'b0;
`endif
                  if (len == '0) begin
                     state_reg <= ST_DONE;
                  end else begin
                     // Issue the first read straight away for one-cycle latency.
                     state_reg <= ST_RD;
                     mem_valid <= 1'b1;
                     mem_addr  <= word_align(src_addr);
                     mem_wstrb <= '0;
                  end
               end
            end

            ST_RD: begin
               if (abort) abort_reg <= 1'b1;
               if (timeout_hit) begin
                  mem_valid <= 1'b0;
                  done      <= 1'b1;
                  state_reg <= ST_DONE;
`ifdef DMA_TIMEOUT_EN
                  error_reg <= 1'b1;
`endif
               end else if (!mem_valid) begin
                  // Re-entry after a write beat: valid was low for one cycle.
                  mem_valid <= 1'b1;
                  mem_addr  <= src_ptr_reg;
                  mem_wstrb <= '0;
               end else if (mem_ready) begin
                  mem_valid <= 1'b0;
                  mem_wdata <= mem_rdata;
                  state_reg <= ST_WR;
               end
            end

            ST_WR: begin
               if (abort) abort_reg <= 1'b1;
               if (timeout_hit) begin
                  mem_valid <= 1'b0;
                  done      <= 1'b1;
                  state_reg <= ST_DONE;
`ifdef DMA_TIMEOUT_EN
                  error_reg <= 1'b1;
`endif
               end else if (!mem_valid) begin
                  mem_valid <= 1'b1;
                  mem_addr  <= dst_ptr_reg;
                  mem_wstrb <= WSTRB_FULL;
               end else if (mem_ready) begin
                  mem_valid   <= 1'b0;
                  src_ptr_reg <= src_ptr_reg + WORD_BYTES;
                  dst_ptr_reg <= dst_ptr_reg + WORD_BYTES;
                  count_reg   <= count_reg - LEN_W'(1);
                  if (last_beat) begin
                     done      <= 1'b1;
                     state_reg <= ST_DONE;
                  end else begin
                     state_reg <= ST_RD;
                  end
               end
            end

            ST_DONE: begin
               // Arriving from a write or timeout, done is already high and this
               // is the pulse cycle. A zero-length copy arrives with done low and
               // raises it one cycle later.
               if (done) begin
                  done      <= 1'b0;
                  busy      <= 1'b0;
                  abort_reg <= 1'b0;
                  state_reg <= ST_IDLE;
               end else begin
                  done <= 1'b1;
               end
            end

            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/dma_copy.md
DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 SHALL have parameter LEN_W, default 16, meaning width of the word-count input and counter.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning cycles to wait for mem_ready before flagging an error (used only with DMA_TIMEOUT_EN).
REQ-003 SHALL have port clk  in  1  system clock; one clock; all state on its rising edge.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a copy.
REQ-006 SHALL have ports src_addr, dst_addr  in  32 each  source and destination byte addresses.
REQ-007 SHALL have port len  in  LEN_W  number of 32-bit words to copy.
REQ-008 SHALL have port abort  in  1  request to stop after the current beat.
REQ-009 SHALL have port busy  out  1  copy in progress.
REQ-010 SHALL have port done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port error  out  1  sticky timeout flag, cleared by next accepted start.
REQ-012 SHALL have ports mem_valid  out  1, mem_addr  out  32, mem_wdata  out  32, mem_wstrb  out  4  bus initiator request.
REQ-013 SHALL have ports mem_ready  in  1, mem_rdata  in  32  bus responder reply, as returned by sys_bus.

Function
REQ-014 SHALL implement states IDLE, RD, WR, DONE.
REQ-015 IDLE: start=1 latches src/dst with bits[1:0] forced 0, latches len, clears error; next state is RD, or DONE if len=0.
REQ-016 start SHALL be ignored in every state other than IDLE.
REQ-017 RD: mem_valid=1, mem_addr=src pointer, mem_wstrb=0; on mem_ready, captures mem_rdata and moves to WR.
REQ-018 WR: mem_valid=1, mem_addr=dst pointer, mem_wdata=captured word, mem_wstrb=4'hF; on mem_ready, increments both pointers by 4 and decrements the count.
REQ-019 After a WR beat, the next state SHALL be DONE if the count reaches 0 or abort is pending, else RD.
REQ-020 Once mem_valid is asserted, it and mem_addr/mem_wdata/mem_wstrb SHALL hold stable until the cycle mem_ready=1.
REQ-021 mem_valid SHALL drop in the cycle after the mem_ready handshake; no back-to-back beats.
REQ-022 Pointers SHALL wrap modulo 2^32 without error.
REQ-023 abort SHALL be latched when asserted in RD or WR, and SHALL take effect after the current WR completes; an abort during RD still completes that word's write.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE.
REQ-025 busy SHALL be 1 in RD, WR and DONE.
REQ-026 Latency: start to first mem_valid SHALL be 1 cycle; the last WR handshake to done SHALL be 1 cycle.

Reset
REQ-027 resetn=0 SHALL immediately force IDLE, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, done=0 and error=0, and clear the pointers, count and abort latch, including mid-transfer.

Configuration
REQ-028 With DMA_TIMEOUT_EN defined, a counter SHALL run while mem_valid=1 and mem_ready=0; reaching TIMEOUT_CYCLES SHALL drop mem_valid, set error and go to DONE.
REQ-029 Without DMA_TIMEOUT_EN, the block SHALL wait indefinitely for mem_ready, and error SHALL be constant 0.

Structure
REQ-030 The state encoding, WSTRB_FULL (4'hF) and WORD_BYTES (4) SHALL live in the shared package sys_bus_pkg.
REQ-031 The timeout counter SHALL be the sub-module dma_timeout (inputs clk, resetn, run; output expired), instantiated only under DMA_TIMEOUT_EN.

Verification
REQ-032 Copy: start with src=0x100, dst=0x200, len=3, and the responder readies each beat after 2 cycles -> read/write pairs occur at 0x100/0x200, 0x104/0x204 and 0x108/0x208; data matches; done pulses once.
REQ-033 Zero length: start with len=0 -> no mem_valid is asserted; done pulses 2 cycles after start.
REQ-034 Abort: abort asserted during the 2nd RD of a len=8 copy -> exactly 2 words are written, then done.
REQ-035 Misaligned addresses and wrap: src=0xFFFFFFFE, len=2 -> reads occur at 0xFFFFFFFC, then 0x00000000.
REQ-036 Reset mid-WR: resetn pulsed low -> mem_valid=0 and busy=0 in the same cycle; a later start runs normally.
REQ-037 Timeout (DMA_TIMEOUT_EN, TIMEOUT_CYCLES=16): mem_ready held at 0 -> mem_valid drops after 16 cycles, error=1, done pulses; the next start clears error.
